// File: rtl/wg_barrier_ctrl.sv
// Workgroup barrier scheduler: counts s_barrier arrivals per workgroup, parks
// arriving wavefronts and releases the whole group in a single pulse.
module wg_barrier_ctrl #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bar_req,
  input  logic [WFID_W-1:0] bar_wfid,
  input  logic [WFID_W-1:0] bar_wgid,
  input  logic [CNT_W-1:0]  bar_wf_count,
  input  logic              halt,
  input  logic [WFID_W-1:0] halt_wfid,
  output logic              bar_release,
  output logic [WFID_W-1:0] bar_release_wgid,
  output logic [NUM_WF-1:0] bar_release_mask,
  output logic [NUM_WF-1:0] wf_waiting,
  output logic              bar_err
);

  logic [NUM_WF-1:0] wait_mask_r;
  logic [WFID_W-1:0] wait_wgid_r [NUM_WF];
  logic [CNT_W-1:0]  arr_cnt_r   [NUM_WF];

  logic              halt_hit_s;
  logic [WFID_W-1:0] halt_wgid_s;
  logic [NUM_WF-1:0] mask_post_s;
  logic [CNT_W-1:0]  cnt_post_s  [NUM_WF];
  logic [NUM_WF-1:0] members_s;
  logic [NUM_WF-1:0] req_bit_s;
  logic [NUM_WF-1:0] wg_bit_s;
  logic              dup_s;
  logic [CNT_W-1:0]  cur_cnt_s;
  logic [CNT_W-1:0]  new_cnt_s;
  logic              same_s;
  logic              range_bad_s;
  logic              bad_s;
  logic              accept_s;
  logic              release_s;
  logic              err_s;
  logic [NUM_WF-1:0] nxt_mask_s;
  logic [CNT_W-1:0]  nxt_cnt_s   [NUM_WF];
  logic [WFID_W-1:0] nxt_wgid_s  [NUM_WF];

  assign wf_waiting = wait_mask_r;

  // Halt step first, then the arrival decision against the post-halt state.
  always_comb begin
    halt_hit_s  = 1'b0;
    halt_wgid_s = {WFID_W{1'b0}};
    mask_post_s = wait_mask_r;
    for (int i = 0; i < NUM_WF; i++) begin
      if (halt && (halt_wfid == WFID_W'(i)) && wait_mask_r[i]) begin
        halt_hit_s     = 1'b1;
        halt_wgid_s    = wait_wgid_r[i];
        mask_post_s[i] = 1'b0;
      end else begin
        mask_post_s[i] = wait_mask_r[i];
      end
    end

    dup_s     = 1'b0;
    cur_cnt_s = {CNT_W{1'b0}};
    for (int j = 0; j < NUM_WF; j++) begin
      if (halt_hit_s && (halt_wgid_s == WFID_W'(j)) && (arr_cnt_r[j] != {CNT_W{1'b0}})) begin
        cnt_post_s[j] = arr_cnt_r[j] - CNT_W'(1);
      end else begin
        cnt_post_s[j] = arr_cnt_r[j];
      end
      req_bit_s[j] = (bar_wfid == WFID_W'(j));
      wg_bit_s[j]  = (bar_wgid == WFID_W'(j));
      members_s[j] = mask_post_s[j] && (wait_wgid_r[j] == bar_wgid);
      dup_s        = dup_s | (mask_post_s[j] & req_bit_s[j]);
      cur_cnt_s    = wg_bit_s[j] ? cnt_post_s[j] : cur_cnt_s;
    end

    new_cnt_s   = cur_cnt_s + CNT_W'(1);
    same_s      = bar_req && halt && (halt_wfid == bar_wfid);
    range_bad_s = (bar_wfid >= WFID_W'(NUM_WF)) || (bar_wgid >= WFID_W'(NUM_WF));
    bad_s       = (bar_wf_count == {CNT_W{1'b0}}) || dup_s || range_bad_s;
    accept_s    = bar_req && !same_s && !bad_s;
    release_s   = accept_s && (new_cnt_s >= bar_wf_count);
    // An overshooting count still releases, but flags the inconsistency.
    err_s       = (bar_req && !same_s && bad_s) || (accept_s && (new_cnt_s > bar_wf_count));

    for (int k = 0; k < NUM_WF; k++) begin
      nxt_mask_s[k] = release_s ? (mask_post_s[k] & ~members_s[k])
                                : (mask_post_s[k] | (accept_s & req_bit_s[k]));
      nxt_cnt_s[k]  = (accept_s && wg_bit_s[k]) ? (release_s ? {CNT_W{1'b0}} : new_cnt_s)
                                                : cnt_post_s[k];
      nxt_wgid_s[k] = (accept_s && !release_s && req_bit_s[k]) ? bar_wgid : wait_wgid_r[k];
    end
  end

  // State and registered release/error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_mask_r      <= {NUM_WF{1'b0}};
      bar_release      <= 1'b0;
      bar_release_wgid <= {WFID_W{1'b0}};
      bar_release_mask <= {NUM_WF{1'b0}};
      bar_err          <= 1'b0;
      for (int i = 0; i < NUM_WF; i++) begin
        wait_wgid_r[i] <= {WFID_W{1'b0}};
        arr_cnt_r[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      wait_mask_r      <= nxt_mask_s;
      bar_release      <= release_s;
      bar_release_wgid <= release_s ? bar_wgid : {WFID_W{1'b0}};
      bar_release_mask <= release_s ? (members_s | req_bit_s) : {NUM_WF{1'b0}};
      bar_err          <= err_s;
      for (int i = 0; i < NUM_WF; i++) begin
        wait_wgid_r[i] <= nxt_wgid_s[i];
        arr_cnt_r[i]   <= nxt_cnt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_wg_barrier_ctrl.sv
// Self-checking bench for wg_barrier_ctrl: vector table applied through a
// scoreboard queue, plus a hand-written mid-barrier reset sequence.
module tb_wg_barrier_ctrl;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              bar_req;
  logic [WFID_W-1:0] bar_wfid;
  logic [WFID_W-1:0] bar_wgid;
  logic [CNT_W-1:0]  bar_wf_count;
  logic              halt;
  logic [WFID_W-1:0] halt_wfid;
  logic              bar_release;
  logic [WFID_W-1:0] bar_release_wgid;
  logic [NUM_WF-1:0] bar_release_mask;
  logic [NUM_WF-1:0] wf_waiting;
  logic              bar_err;

  wg_barrier_ctrl #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bar_req(bar_req), .bar_wfid(bar_wfid),
    .bar_wgid(bar_wgid), .bar_wf_count(bar_wf_count), .halt(halt),
    .halt_wfid(halt_wfid), .bar_release(bar_release),
    .bar_release_wgid(bar_release_wgid), .bar_release_mask(bar_release_mask),
    .wf_waiting(wf_waiting), .bar_err(bar_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              req;
    logic [WFID_W-1:0] wfid;
    logic [WFID_W-1:0] wgid;
    logic [CNT_W-1:0]  cnt;
    logic              hlt;
    logic [WFID_W-1:0] hwfid;
    logic              rel;
    logic [WFID_W-1:0] rwgid;
    logic [NUM_WF-1:0] rmask;
    logic              err;
    logic [NUM_WF-1:0] waitm;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic req, int wfid, int wgid, int cnt, logic hlt, int hwfid,
                              logic rel, int rwgid, logic [NUM_WF-1:0] rmask, logic err,
                              logic [NUM_WF-1:0] waitm);
    vec_t v;
    v.req = req; v.wfid = WFID_W'(wfid); v.wgid = WFID_W'(wgid); v.cnt = CNT_W'(cnt);
    v.hlt = hlt; v.hwfid = WFID_W'(hwfid);
    v.rel = rel; v.rwgid = WFID_W'(rwgid); v.rmask = rmask; v.err = err; v.waitm = waitm;
    return v;
  endfunction

  function automatic logic [NUM_WF-1:0] bit_of(int n);
    logic [NUM_WF-1:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    bar_req = v.req; bar_wfid = v.wfid; bar_wgid = v.wgid; bar_wf_count = v.cnt;
    halt = v.hlt; halt_wfid = v.hwfid;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("release", idx, 64'(bar_release), 64'(e.rel));
    check("release_wgid", idx, 64'(bar_release_wgid), 64'(e.rwgid));
    check("release_mask", idx, 64'(bar_release_mask), 64'(e.rmask));
    check("err", idx, 64'(bar_err), 64'(e.err));
    check("waiting", idx, 64'(wf_waiting), 64'(e.waitm));
  endtask

  task automatic check_all_zero(string name);
    check({name, "_release"}, -1, 64'(bar_release), 64'd0);
    check({name, "_wgid"}, -1, 64'(bar_release_wgid), 64'd0);
    check({name, "_mask"}, -1, 64'(bar_release_mask), 64'd0);
    check({name, "_err"}, -1, 64'(bar_err), 64'd0);
    check({name, "_waiting"}, -1, 64'(wf_waiting), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //             req wf  wg cnt hlt hw  rel rwg rmask                         err waiting
    // group 4, three arrivals, then counter-reset probe with count 1
    vecs.push_back(mk(1, 4, 4, 3, 0, 0,  0, 0,  '0, 0, bit_of(4)));
    vecs.push_back(mk(1, 5, 4, 3, 0, 0,  0, 0,  '0, 0, bit_of(4) | bit_of(5)));
    vecs.push_back(mk(1, 6, 4, 3, 0, 0,  1, 4,  40'h70, 0, '0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,  '0, 0, '0));
    vecs.push_back(mk(1, 4, 4, 1, 0, 0,  1, 4,  bit_of(4), 0, '0));
    // single-wave group
    vecs.push_back(mk(1, 9, 9, 1, 0, 0,  1, 9,  bit_of(9), 0, '0));
    // interleaved groups 0 and 2
    vecs.push_back(mk(1, 0, 0, 2, 0, 0,  0, 0,  '0, 0, 40'h1));
    vecs.push_back(mk(1, 2, 2, 2, 0, 0,  0, 0,  '0, 0, 40'h5));
    vecs.push_back(mk(1, 3, 2, 2, 0, 0,  1, 2,  40'hC, 0, 40'h1));
    vecs.push_back(mk(1, 1, 0, 2, 0, 0,  1, 0,  40'h3, 0, '0));
    // halt handling on group 10
    vecs.push_back(mk(1, 10, 10, 3, 0, 0,  0, 0, '0, 0, bit_of(10)));
    vecs.push_back(mk(0, 0, 0, 0, 1, 10,   0, 0, '0, 0, '0));
    vecs.push_back(mk(1, 11, 10, 3, 1, 12, 0, 0, '0, 0, bit_of(11)));
    vecs.push_back(mk(1, 12, 10, 3, 0, 0,  0, 0, '0, 0, bit_of(11) | bit_of(12)));
    vecs.push_back(mk(1, 13, 10, 3, 0, 0,  1, 10, 40'h3800, 0, '0));
    // zero count, duplicate, same-cycle halt+request
    vecs.push_back(mk(1, 20, 20, 0, 0, 0,  0, 0, '0, 1, '0));
    vecs.push_back(mk(1, 20, 20, 2, 0, 0,  0, 0, '0, 0, bit_of(20)));
    vecs.push_back(mk(1, 20, 20, 2, 0, 0,  0, 0, '0, 1, bit_of(20)));
    vecs.push_back(mk(1, 21, 20, 2, 0, 0,  1, 20, bit_of(20) | bit_of(21), 0, '0));
    vecs.push_back(mk(1, 22, 22, 2, 1, 22, 0, 0, '0, 0, '0));
    vecs.push_back(mk(1, 23, 22, 2, 0, 0,  0, 0, '0, 0, bit_of(23)));
    vecs.push_back(mk(1, 24, 22, 2, 0, 0,  1, 22, bit_of(23) | bit_of(24), 0, '0));
    // out-of-range ids
    vecs.push_back(mk(1, 45, 1, 2, 0, 0,  0, 0, '0, 1, '0));
    vecs.push_back(mk(1, 1, 40, 2, 0, 0,  0, 0, '0, 1, '0));
    // inconsistent count overshoot
    vecs.push_back(mk(1, 30, 30, 3, 0, 0,  0, 0, '0, 0, bit_of(30)));
    vecs.push_back(mk(1, 31, 30, 1, 0, 0,  1, 30, bit_of(30) | bit_of(31), 1, '0));
    // halt decrement on the group being requested in the same cycle
    vecs.push_back(mk(1, 32, 32, 2, 0, 0,  0, 0, '0, 0, bit_of(32)));
    vecs.push_back(mk(1, 33, 32, 2, 1, 32, 0, 0, '0, 0, bit_of(33)));
    vecs.push_back(mk(1, 34, 32, 2, 0, 0,  1, 32, bit_of(33) | bit_of(34), 0, '0));
    vecs.push_back(mk(1, 39, 39, 2, 0, 0,  0, 0, '0, 0, bit_of(39)));
    vecs.push_back(mk(1, 38, 39, 2, 0, 0,  1, 39, bit_of(38) | bit_of(39), 0, '0));

    rst = 1'b0; bar_req = 1'b0; bar_wfid = '0; bar_wgid = '0; bar_wf_count = '0;
    halt = 1'b0; halt_wfid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Mid-barrier async reset: two waves parked, then reset between edges.
    apply(mk(1, 5, 5, 3, 0, 0, 0, 0, '0, 0, bit_of(5)), 100);
    apply(mk(1, 6, 5, 3, 0, 0, 0, 0, '0, 0, bit_of(5) | bit_of(6)), 101);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    bar_req = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    apply(mk(1, 5, 5, 2, 0, 0, 0, 0, '0, 0, bit_of(5)), 102);
    apply(mk(1, 6, 5, 2, 0, 0, 1, 5, bit_of(5) | bit_of(6), 0, '0), 103);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, '0, 0, '0), 104);

    check("scoreboard_empty", -1, 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wg_barrier_ctrl.md
Name: wg_barrier_ctrl

Overview:
- Workgroup barrier scheduler for the issue stage.
- Sits beside the wavegroup info table. On each s_barrier it receives the wavefront's wgid and wavegroup wf_count, as looked up from that table.
- Counts arrivals per workgroup and parks arriving wavefronts. Once every wavefront of the group has arrived, it releases them all in one pulse.
- Tracks halted wavefronts so a dead waiter never stays parked.

Parameters:
- NUM_WF, 40, number of wavefront slots; also the number of per-wgid counters (wgid is a wfid, so wgid < NUM_WF).
- WFID_W, 6, width of wfid/wgid.
- CNT_W, 4, width of wf_count and the arrival counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bar_req  in  1  barrier arrival strobe, one per cycle maximum.
- bar_wfid  in  WFID_W  arriving wavefront.
- bar_wgid  in  WFID_W  workgroup id of the arriving wavefront.
- bar_wf_count  in  CNT_W  number of wavefronts in the workgroup.
- halt  in  1  wavefront termination strobe.
- halt_wfid  in  WFID_W  terminating wavefront.
- bar_release  out  1  one-cycle pulse: a barrier completed.
- bar_release_wgid  out  WFID_W  workgroup released.
- bar_release_mask  out  NUM_WF  wfids released (one-hot set).
- wf_waiting  out  NUM_WF  bit i = wfid i parked at a barrier (issue must not select it).
- bar_err  out  1  one-cycle pulse: illegal request dropped.

Behaviour:
- State:
  - wait_mask[NUM_WF]
  - per-wfid wait_wgid[WFID_W]
  - per-wgid arr_cnt[CNT_W]
- Reset (rst=0, async): all state 0; bar_release=0, bar_release_wgid=0, bar_release_mask=0, bar_err=0; wf_waiting=0.
- wf_waiting = wait_mask, combinational from registers.
- All other outputs are registered, so latency is 1 cycle: a request sampled at edge N shows its release/err after edge N.
- Halt step, evaluated first:
  - If halt and wait_mask[halt_wfid] is set: clear that bit, and decrement arr_cnt[wait_wgid[halt_wfid]] (saturating at 0).
  - Halt of a non-waiting wfid: no effect.
- Request validity: the request is dropped and bar_err pulses if any of these hold:
  - bar_wf_count == 0
  - wait_mask[bar_wfid] is already set (and bar_wfid is not being halted this cycle)
  - bar_wfid >= NUM_WF or bar_wgid >= NUM_WF
- Halt and request with the same wfid in the same cycle: the halt wins. The request is dropped silently, with no bar_err.
- Accepted request:
  - new_cnt = arr_cnt[bar_wgid], after any halt decrement on the same group, + 1.
  - If new_cnt == bar_wf_count (release):
    - arr_cnt[bar_wgid] <= 0.
    - bar_release <= 1 and bar_release_wgid <= bar_wgid.
    - bar_release_mask <= post-halt wait_mask members with wait_wgid == bar_wgid, plus bit bar_wfid.
    - Those bits are cleared in wait_mask; the requester never sets its bit.
  - Otherwise: arr_cnt[bar_wgid] <= new_cnt, set wait_mask[bar_wfid], wait_wgid[bar_wfid] <= bar_wgid.
- bar_wf_count == 1 releases immediately. The mask contains only the requester.
- bar_wf_count is taken from each request and is not stored. If new_cnt > bar_wf_count (inconsistent count):
  - Treat as release: same action as equality.
  - Also pulse bar_err.
- Back-to-back requests to the same group see the already-updated counter. State updates every cycle, so no bypass is needed.
- Different groups are independent; any number of groups may be open at once.
- Reset mid-barrier discards all parked wavefronts; there is no release pulse.
- Release outputs are single-cycle: 0 on the next cycle unless a new release occurs.

Test Plan:
- Group wgid=4, wf_count=3, wfids 4,5,6 request on consecutive cycles.
  - wf_waiting: bit4 set, then bits 4|5 set, then cleared.
  - bar_release=1, wgid=4, mask=0x70 the cycle after wfid 6's request.
  - arr_cnt[4] returns to 0.
- wf_count=1 request from wfid 9 (wgid 9) -> next cycle bar_release=1, wgid=9, mask=bit9. wf_waiting never sets bit9.
- Interleaved groups:
  - Sequence: wgid 0 (count 2: wfids 0,1) and wgid 2 (count 2: wfids 2,3), order 0,2,3,1.
  - Release wgid 2 with mask 0x0C after wfid 3.
  - Release wgid 0 with mask 0x03 after wfid 1.
- Halt handling, wgid=10, count=3:
  - wfid 10 arrives; halt of wfid 10 -> wait bit clears, arr_cnt[10]=0.
  - Later, wfid 11 requests in the same cycle as halt of wfid 12 (not waiting) -> arr_cnt[10]=1, no release.
- Error cases:
  - bar_wf_count=0 -> bar_err pulse, no state change.
  - Duplicate request from a waiting wfid -> bar_err, count unchanged.
  - Same-cycle halt+request on one wfid -> no err, no wait bit.
- Async reset asserted mid-cycle with two waves parked -> all outputs 0 immediately. After deassert, a fresh 2-wave barrier releases normally.
